// File: rtl/pwm_led_pkg.sv
// pwm_led_pkg: shared constants for the multi-channel PWM LED driver.
//   Register addresses on the peripheral bus and CTRL bit positions.
package pwm_led_pkg;

   // Register map. Duty shadows occupy ADDR_DUTY0 .. ADDR_DUTY0+7.
   localparam int unsigned ADDR_DUTY0    = 32'h0;
   localparam int unsigned ADDR_TOP      = 32'h8;
   localparam int unsigned ADDR_PRESCALE = 32'h9;
   localparam int unsigned ADDR_CTRL     = 32'hA;
   localparam int unsigned ADDR_POL      = 32'hB;
   localparam int unsigned ADDR_STEP     = 32'hC;
   localparam int unsigned ADDR_CNT      = 32'hD;
   localparam int unsigned ADDR_SEL      = 32'hE;

   // CTRL register bit indices.
   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_FADE = 1;

   localparam int unsigned MAX_CHANNELS = 8;

endpackage

// File: rtl/pwm_led_channel.sv
// pwm_led_channel: one PWM output lane.
//   Holds the bus-written duty shadow, the active duty used for compare,
//   the fade-toward-target arithmetic and the registered output pin.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   wr_i, wdata_i    shadow write strobe and data
//   boundary_i       period boundary (counter wrap on a tick)
//   en_i, fade_i     CTRL enable / fade mode
//   step_i           fade increment per period
//   cnt_i            shared period counter
//   pol_i            1 = inverted output
//   shadow_o         shadow duty readback
//   active_o         active duty readback
//   pin_o            registered PWM output
module pwm_led_channel
   import pwm_led_pkg::*;
#(
   parameter int BITS = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            wr_i,
   input  logic [BITS-1:0] wdata_i,
   input  logic            boundary_i,
   input  logic            en_i,
   input  logic            fade_i,
   input  logic [BITS-1:0] step_i,
   input  logic [BITS-1:0] cnt_i,
   input  logic            pol_i,
   output logic [BITS-1:0] shadow_o,
   output logic [BITS-1:0] active_o,
   output logic            pin_o
);

   logic [BITS-1:0] shadow_q;
   logic [BITS-1:0] active_q, active_d;
   logic            pin_q, pin_d;

   // Fade moves by at most STEP and lands exactly on the target; the
   // difference is taken in the direction that cannot wrap.
   always_comb begin
      active_d = active_q;
      if (!en_i) begin
         active_d = shadow_q;
      end else if (boundary_i) begin
         if (!fade_i || (step_i == '0)) begin
            active_d = shadow_q;
         end else if (shadow_q > active_q) begin
            active_d = ((shadow_q - active_q) > step_i) ? (active_q + step_i) : shadow_q;
         end else begin
            active_d = ((active_q - shadow_q) > step_i) ? (active_q - step_i) : shadow_q;
         end
      end
   end

   // Disabled lanes sit at their inactive level, which is the polarity bit.
   always_comb begin
      pin_d = pol_i;
      if (en_i) pin_d = (cnt_i < active_q) ^ pol_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         active_q <= '0;
         pin_q    <= 1'b0;
      end else begin
         if (wr_i) shadow_q <= wdata_i;
         active_q <= active_d;
         pin_q    <= pin_d;
      end
   end

   assign shadow_o = shadow_q;
   assign active_o = active_q;
   assign pin_o    = pin_q;

endmodule

// File: rtl/pwm_led_multi.sv
// pwm_led_multi: parametrised multi-channel PWM LED driver.
//   Bus register file, clock prescaler and shared period counter; one
//   pwm_led_channel per output.
// Ports:
//   CLK, RST   clock, asynchronous active-high reset
//   ADDRESS    register select
//   DATA_IN    write data
//   DATA_OUT   combinational readback of the addressed register
//   WR         single-cycle write strobe
//   PINS       registered PWM outputs, bit n = channel n
module pwm_led_multi
   import pwm_led_pkg::*;
#(
   parameter int BITS         = 16,
   parameter int ADDRESS_BITS = 4,
   parameter int CHANNELS     = 3
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [ADDRESS_BITS-1:0] ADDRESS,
   input  logic [BITS-1:0]         DATA_IN,
   output logic [BITS-1:0]         DATA_OUT,
   input  logic                    WR,
   output logic [CHANNELS-1:0]     PINS
);

   localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

   logic [31:0]         addr;
   logic [BITS-1:0]     top_q, prescale_q, step_q;
   logic                en_q, fade_q;
   logic [CHANNELS-1:0] pol_q;
   logic [2:0]          sel_q;
   logic [BITS-1:0]     pcnt_q, pcnt_d;
   logic [BITS-1:0]     cnt_q, cnt_d;
   logic                tick, boundary;

   logic [CHANNELS-1:0]           duty_wr;
   logic [CHANNELS-1:0][BITS-1:0] shadow, active;

   // Full-width compare so aliases above 0xF never hit a register.
   assign addr = 32'(ADDRESS);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         top_q      <= '0;
         prescale_q <= '0;
         step_q     <= '0;
         en_q       <= 1'b0;
         fade_q     <= 1'b0;
         pol_q      <= '0;
         sel_q      <= '0;
      end else if (WR) begin
         case (addr)
            ADDR_TOP:      top_q      <= DATA_IN;
            ADDR_PRESCALE: prescale_q <= DATA_IN;
            ADDR_STEP:     step_q     <= DATA_IN;
            ADDR_POL:      pol_q      <= DATA_IN[CHANNELS-1:0];
            ADDR_SEL:      sel_q      <= DATA_IN[2:0];
            ADDR_CTRL: begin
               en_q   <= DATA_IN[CTRL_EN];
               fade_q <= DATA_IN[CTRL_FADE];
            end
            default: ;
         endcase
      end
   end

   // >= rather than == so a TOP/PRESCALE lowered below the running count
   // wraps on the next tick instead of running to 2^BITS.
   assign tick     = en_q && (pcnt_q >= prescale_q);
   assign boundary = tick && (cnt_q >= top_q);

   always_comb begin
      pcnt_d = pcnt_q;
      cnt_d  = cnt_q;
      if (!en_q) begin
         pcnt_d = '0;
         cnt_d  = '0;
      end else if (tick) begin
         pcnt_d = '0;
         cnt_d  = boundary ? '0 : (cnt_q + ONE);
      end else begin
         pcnt_d = pcnt_q + ONE;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pcnt_q <= '0;
         cnt_q  <= '0;
      end else begin
         pcnt_q <= pcnt_d;
         cnt_q  <= cnt_d;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      assign duty_wr[g] = WR && (addr == 32'(ADDR_DUTY0 + g));

      pwm_led_channel #(.BITS(BITS)) u_ch (
         .clk_i      (CLK),
         .rst_i      (RST),
         .wr_i       (duty_wr[g]),
         .wdata_i    (DATA_IN),
         .boundary_i (boundary),
         .en_i       (en_q),
         .fade_i     (fade_q),
         .step_i     (step_q),
         .cnt_i      (cnt_q),
         .pol_i      (pol_q[g]),
         .shadow_o   (shadow[g]),
         .active_o   (active[g]),
         .pin_o      (PINS[g])
      );
   end

   always_comb begin
      DATA_OUT = '0;
      case (addr)
         ADDR_TOP:      DATA_OUT = top_q;
         ADDR_PRESCALE: DATA_OUT = prescale_q;
         ADDR_STEP:     DATA_OUT = step_q;
         ADDR_CNT:      DATA_OUT = cnt_q;
         ADDR_CTRL: begin
            DATA_OUT[CTRL_EN]   = en_q;
            DATA_OUT[CTRL_FADE] = fade_q;
         end
         ADDR_POL:      DATA_OUT[CHANNELS-1:0] = pol_q;
         ADDR_SEL: begin
            for (int unsigned n = 0; n < CHANNELS; n++)
               if (32'(sel_q) == n) DATA_OUT = active[n];
         end
         default: begin
            // Unimplemented duty slots (n >= CHANNELS) fall through to 0.
            for (int unsigned n = 0; n < CHANNELS; n++)
               if (addr == ADDR_DUTY0 + n) DATA_OUT = shadow[n];
         end
      endcase
   end

endmodule

// File: tb/tb_pwm_led_multi.sv
// tb_pwm_led_multi: directed bench for pwm_led_multi (3 channels, 16 bits).
module tb_pwm_led_multi;

   localparam int BITS = 16;
   localparam int AB   = 4;
   localparam int CH   = 3;

   localparam logic [3:0] A_TOP = 4'h8, A_PRE = 4'h9, A_CTRL = 4'hA, A_POL = 4'hB,
                          A_STEP = 4'hC, A_CNT = 4'hD, A_SEL = 4'hE;

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic            WR  = 1'b0;
   logic [AB-1:0]   ADDRESS = '0;
   logic [BITS-1:0] DATA_IN = '0;
   logic [BITS-1:0] DATA_OUT;
   logic [CH-1:0]   PINS;

   always #5 CLK = ~CLK;

   pwm_led_multi #(.BITS(BITS), .ADDRESS_BITS(AB), .CHANNELS(CH)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .ADDRESS  (ADDRESS),
      .DATA_IN  (DATA_IN),
      .DATA_OUT (DATA_OUT),
      .WR       (WR),
      .PINS     (PINS)
   );

   typedef struct {
      string           tag;
      logic [BITS-1:0] exp;
   } sb_t;

   sb_t sb[$];
   int  checks = 0;
   int  errors = 0;

   task automatic push(input string tag, input logic [BITS-1:0] v);
      sb_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input logic [BITS-1:0] obs);
      sb_t e;
      e = sb.pop_front();
      checks++;
      assert (obs === e.exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
   endtask

   // All stimulus tasks are entered in the low clock phase.
   task automatic wr(input logic [3:0] a, input logic [BITS-1:0] d);
      ADDRESS = a;
      DATA_IN = d;
      WR      = 1'b1;
      @(negedge CLK);
      WR      = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [BITS-1:0] v, input string tag);
      push(tag, v);
      ADDRESS = a;
      #1;
      pop_cmp(DATA_OUT);
   endtask

   task automatic chk_cnt(input int v, input string tag);
      rd(A_CNT, 16'(v), tag);
   endtask

   task automatic chk_pins(input logic [CH-1:0] v, input string tag);
      push(tag, 16'(v));
      pop_cmp(16'(PINS));
   endtask

   task automatic wait_cnt(input int v);
      logic found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge CLK);
         ADDRESS = A_CNT;
         #1;
         if (DATA_OUT == 16'(v)) found = 1'b1;
      end
      push("wait_cnt", 16'd1);
      pop_cmp(16'(found));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CH-1:0]   p;
      logic [BITS-1:0] up [4];
      logic [BITS-1:0] dn [5];
      up = '{16'd2, 16'd4, 16'd6, 16'd7};
      dn = '{16'd5, 16'd3, 16'd1, 16'd0, 16'd0};

      // Reset and idle
      #1;
      chk_pins(3'b000, "pins_in_reset");
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      for (int a = 0; a < 16; a++) rd(4'(a), 16'd0, "reset_readback");
      @(negedge CLK);

      // Basic duty: TOP=9, PRESCALE=0, duties 3/0/15
      wr(A_TOP, 16'd9);
      wr(A_PRE, 16'd0);
      wr(4'h0, 16'd3);
      wr(4'h1, 16'd0);
      wr(4'h2, 16'd15);
      rd(A_TOP, 16'd9, "top_readback");
      rd(4'h2, 16'd15, "duty2_readback");
      rd(4'h3, 16'd0, "duty3_unimpl");
      wr(A_CTRL, 16'd1);
      for (int k = 0; k < 20; k++) begin
         p    = '0;
         p[0] = (k >= 1) && (((k - 1) % 10) < 3);
         p[2] = (k >= 1);
         chk_cnt(k % 10, "basic_cnt");
         chk_pins(p, "basic_pins");
         @(negedge CLK);
      end

      // Shadow write mid-period applies at the next wrap
      wait_cnt(5);
      wr(4'h0, 16'd7);
      for (int j = 1; j <= 20; j++) begin
         p    = 3'b100;
         p[0] = ((4 + j) % 10) < ((j >= 6) ? 7 : 3);
         chk_cnt((5 + j) % 10, "latch_cnt");
         chk_pins(p, "latch_pins");
         @(negedge CLK);
      end

      // Shadow write on the exact wrap cycle applies one period later
      wait_cnt(9);
      wr(4'h0, 16'd2);
      for (int j = 1; j <= 20; j++) begin
         p    = 3'b100;
         p[0] = ((8 + j) % 10) < ((j >= 12) ? 2 : 7);
         chk_cnt((9 + j) % 10, "wrapwr_cnt");
         chk_pins(p, "wrapwr_pins");
         @(negedge CLK);
      end

      // Prescaler 3, TOP 4: 20-clock period
      wr(A_CTRL, 16'd0);
      wr(A_PRE, 16'd3);
      wr(A_TOP, 16'd4);
      wr(A_CTRL, 16'd1);
      for (int k = 0; k < 24; k++) begin
         p    = '0;
         p[0] = (k >= 1) && ((((k - 1) / 4) % 5) < 2);
         p[2] = (k >= 1);
         chk_cnt((k / 4) % 5, "presc_cnt");
         chk_pins(p, "presc_pins");
         @(negedge CLK);
      end

      // TOP lowered below CNT wraps on the next tick
      wait_cnt(3);
      wr(A_TOP, 16'd1);
      for (int j = 1; j <= 15; j++) begin
         chk_cnt((j < 4) ? 3 : (((j - 4) / 4) % 2), "toplow_cnt");
         @(negedge CLK);
      end

      // Fade, STEP=2: up to 7 then back down to 0
      wr(A_CTRL, 16'd0);
      wr(A_PRE, 16'd0);
      wr(A_TOP, 16'd9);
      wr(4'h0, 16'd0);
      wr(A_STEP, 16'd2);
      wr(A_SEL, 16'd0);
      wr(A_CTRL, 16'd3);
      rd(A_CTRL, 16'd3, "ctrl_readback");
      rd(A_STEP, 16'd2, "step_readback");
      wr(4'h0, 16'd7);
      for (int i = 0; i < 4; i++) begin
         wait_cnt(5);
         wait_cnt(0);
         rd(A_SEL, up[i], "fade_up");
      end
      wr(4'h0, 16'd0);
      for (int i = 0; i < 5; i++) begin
         wait_cnt(5);
         wait_cnt(0);
         rd(A_SEL, dn[i], "fade_down");
      end

      // Polarity with EN=0, then enable
      wr(A_CTRL, 16'd0);
      wr(A_POL, 16'd2);
      wr(4'h0, 16'd0);
      wr(4'h1, 16'd3);
      wr(4'h2, 16'd0);
      chk_pins(3'b010, "pol_idle_pins");
      rd(A_POL, 16'd2, "pol_readback");
      wr(A_CTRL, 16'd1);
      for (int k = 0; k < 20; k++) begin
         p    = '0;
         p[1] = (k >= 1) ? !(((k - 1) % 10) < 3) : 1'b1;
         chk_cnt(k % 10, "pol_cnt");
         chk_pins(p, "pol_pins");
         @(negedge CLK);
      end

      // Asynchronous reset mid-run with all outputs inverted
      wr(A_POL, 16'd7);
      @(negedge CLK);
      @(negedge CLK);
      push("pol_inv_pre", 16'd1);
      pop_cmp(16'(PINS[0]));
      @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      chk_pins(3'b000, "pins_async_reset");
      rd(A_POL, 16'd0, "rst_pol");
      rd(A_TOP, 16'd0, "rst_top");
      rd(4'h1, 16'd0, "rst_duty1");
      rd(A_CNT, 16'd0, "rst_cnt");
      @(negedge CLK);
      RST = 1'b0;
      repeat (4) @(negedge CLK);
      chk_cnt(0, "idle_cnt_after_rst");
      chk_pins(3'b000, "idle_pins_after_rst");
      rd(A_CTRL, 16'd0, "idle_ctrl_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_led_multi.md
Name: pwm_led_multi

Overview:
Parametrised multi-channel PWM LED driver and successor to the fixed 3-channel RGB PWM block, with CHANNELS independent outputs. Sits on the peripheral register bus with the same ADDRESS/DATA_IN/DATA_OUT/WR interface. Adds:
- programmable period (TOP) and clock prescaler;
- glitch-free duty updates latched at period boundaries;
- per-channel output polarity;
- optional linear fade toward the target duty.

Parameters:
BITS, 16, data/register width; also the width of the counter, duty, TOP and prescaler.
ADDRESS_BITS, 4, bus address width; must be at least 4.
CHANNELS, 3, number of PWM outputs, 1..8.

Ports:
CLK  input  1  system clock; all logic is on the rising edge.
RST  input  1  asynchronous, active-high reset.
ADDRESS  input  ADDRESS_BITS  register select.
DATA_IN  input  BITS  write data.
DATA_OUT  output  BITS  combinational readback of the addressed register.
WR  input  1  write strobe; single-cycle, sampled at the CLK edge.
PINS  output  CHANNELS  registered PWM outputs; bit n is channel n.

Behaviour:
- Register map (write when WR=1 at the clock edge; reads combinational):
  - 0x0..0x7: DUTY_SHADOW[n] for n < CHANNELS. Addresses n >= CHANNELS read 0 and ignore writes.
  - 0x8: TOP. Period is TOP+1 counter ticks.
  - 0x9: PRESCALE. One counter tick every PRESCALE+1 clocks.
  - 0xA: CTRL. bit0 EN, bit1 FADE; other bits read 0.
  - 0xB: POL[CHANNELS-1:0]. 1 = inverted output.
  - 0xC: STEP. Fade increment per period.
  - 0xD: CNT. Read-only current counter value.
  - 0xE: DUTY_ACTIVE of the channel selected by DATA_IN[2:0] of the last write to 0xE. Read-only view; the write only stores the selector.
  - Other addresses read 0; writes to them are ignored.
- Reset (asynchronous, RST=1):
  - all registers, prescaler count, counter and active duties are 0;
  - PINS = 0;
  - the block stays idle until EN=1 after RST is released.
- Prescaler:
  - pcnt counts 0..PRESCALE;
  - tick = EN && (pcnt >= PRESCALE);
  - on tick, pcnt returns to 0.
- Counter, on each tick:
  - if CNT >= TOP, then CNT <= 0 and a period boundary occurs;
  - else CNT <= CNT+1.
  - A TOP write below the current CNT wraps on the next tick, with no runaway to 2^BITS.
- Period boundary, per channel:
  - FADE=0 or STEP=0: DUTY_ACTIVE[n] <= DUTY_SHADOW[n].
  - FADE=1 and STEP>0: DUTY_ACTIVE moves toward the shadow by min(STEP, |shadow-active|).
  - Saturating, never overshoots, no wrap.
- Simultaneous events:
  - a shadow write in the same cycle as a boundary is not seen; the pre-write shadow value is latched and the new value applies at the next boundary;
  - writes to TOP, PRESCALE, POL and CTRL take effect the next cycle.
- Output:
  - raw[n] = (CNT < DUTY_ACTIVE[n]); PINS[n] <= raw[n] XOR POL[n], registered;
  - latency is 1 clock from CNT/DUTY_ACTIVE change to PINS;
  - DUTY_ACTIVE=0 gives constant inactive; DUTY_ACTIVE > TOP gives constant active (100%).
- EN=0:
  - pcnt and CNT are held at 0 and no boundaries occur;
  - DUTY_ACTIVE is loaded directly from the shadow every cycle, so it is ready at enable;
  - PINS = POL (all inactive).
- EN 0->1: the first tick occurs PRESCALE+1 clocks later.
- Reset mid-operation: immediate asynchronous return to the reset state, including PINS=0 regardless of POL.

Decomposition:
- Package pwm_led_pkg holds:
  - register address localparams (ADDR_DUTY0, ADDR_TOP, ADDR_PRESCALE, ADDR_CTRL, ADDR_POL, ADDR_STEP, ADDR_CNT, ADDR_SEL);
  - CTRL bit indices (CTRL_EN=0, CTRL_FADE=1).
- One sub-module, pwm_led_channel, instantiated CHANNELS times via generate. It holds the shadow input, active duty register, fade arithmetic, compare and output flop. Inputs: boundary, EN, FADE, STEP, CNT, POL bit.
- The top level holds the bus decode, prescaler and counter.

Test Plan:
- Reset/idle: assert RST mid-run with POL=0x7. PINS go to 0 immediately; all readbacks are 0; CNT stays 0 after release with EN=0.
- Basic duty: TOP=9, PRESCALE=0, DUTY0=3, DUTY1=0, DUTY2=15, EN=1. PINS[0] is high 3 of every 10 clocks, PINS[1] is always 0, PINS[2] is always 1; PINS lags CNT by 1 clock.
- Boundary latch: with DUTY0=3 running, write DUTY0=7 at CNT=5. PINS[0] keeps the 3/10 pattern until the wrap, then becomes 7/10. A write on the exact wrap cycle applies one period later.
- Prescaler/TOP change: PRESCALE=3, TOP=4. Period is 20 clocks. Write TOP=1 while CNT=3; CNT wraps to 0 on the next tick.
- Fade: FADE=1, STEP=2, shadow 0->7. DUTY_ACTIVE (via 0xE) goes 2,4,6,7 at successive boundaries. Then shadow=0 gives 5,3,1,0, with no underflow.
- Polarity/enable: POL=0x2, EN=0 gives PINS=3'b010. Setting EN=1 with DUTY1=3, TOP=9 gives PINS[1] low 3 of 10 clocks, with the first tick PRESCALE+1 clocks after EN.
